mod241_serial_reducer: RTL and testbench



---
 rtl/mod241_pkg.sv | 21 ++
 rtl/mod241_horner_step.sv | 37 +++
 rtl/mod241_serial_reducer.sv | 107 ++++++++++
 tb/tb_mod241_serial_reducer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod241_pkg.sv
// mod241_pkg
//   Shared constants, FSM state type and helper function for the serial
//   modulo-241 reducer and its Horner-step datapath.
package mod241_pkg;

  localparam int MOD    = 241;
  localparam int RES_W  = 8;
  // 2^8 mod 241: lets the datapath fold bits above bit 7 back into the low byte.
  localparam int FOLD_K = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/mod241_horner_step.sv
// mod241_horner_step
//   Purely combinational Horner step: nxt_o = (acc_i * 2^CHUNK + chunk_i) mod 241.
//   acc_i is assumed to already be below 241.
// Ports
//   acc_i    in  8      running residue (< 241)
//   chunk_i  in  CHUNK  next operand chunk, MSB-first
//   nxt_o    out 8      updated residue (< 241)
module mod241_horner_step
  import mod241_pkg::*;
#(
  parameter int CHUNK = 6
) (
  input  logic [RES_W-1:0] acc_i,
  input  logic [CHUNK-1:0] chunk_i,
  output logic [RES_W-1:0] nxt_o
);

  localparam int T_W = RES_W + CHUNK;

  logic [T_W-1:0] t;
  logic [11:0]    fold1;
  logic [8:0]     fold2;

  // acc*2^CHUNK + chunk is just the concatenation.
  assign t = {acc_i, chunk_i};

  // First fold: the high CHUNK bits weigh 2^8 = 15 (mod 241).
  // Worst case (CHUNK=8) is 255 + 15*240 = 3855, so 12 bits suffice.
  assign fold1 = 12'(t[7:0]) + 12'(FOLD_K) * 12'(t[T_W-1:8]);

  // Second fold leaves at most 255 + 15*15 = 480, below 2*241,
  // so a single conditional subtract lands in 0..240.
  assign fold2 = 9'(fold1[7:0]) + 9'(FOLD_K) * 9'(fold1[11:8]);

  assign nxt_o = (fold2 >= 9'(MOD)) ? 8'(fold2 - 9'(MOD)) : fold2[7:0];

endmodule

// File: rtl/mod241_serial_reducer.sv
// mod241_serial_reducer
//   Reduces a wide OP_W-bit operand modulo 241, consuming CHUNK bits per cycle
//   MSB-first through one shared Horner-step datapath. The result appears
//   NCHUNK clock edges after the operand is accepted.
// Ports
//   clk            in   1      clock, rising edge
//   rst            in   1      asynchronous active-high reset
//   in_valid_i     in   1      operand offered
//   in_ready_o     out  1      high only in IDLE
//   in_operand_i   in   OP_W   unsigned operand, sampled on in_valid_i & in_ready_o
//   out_valid_o    out  1      residue available (DONE)
//   out_ready_i    in   1      consumer accepts residue
//   out_residue_o  out  8      residue 0..240, held until the next DONE
//   busy_o         out  1      high in RUN or DONE
module mod241_serial_reducer
  import mod241_pkg::*;
#(
  parameter int OP_W  = 500,
  parameter int CHUNK = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [OP_W-1:0]  in_operand_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [RES_W-1:0] out_residue_o,
  output logic             busy_o
);

  localparam int NCHUNK = ceil_div(OP_W, CHUNK);
  localparam int PAD_W  = NCHUNK * CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t           state_q, state_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [PAD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] step_nxt;

  mod241_horner_step #(
    .CHUNK(CHUNK)
  ) u_step (
    .acc_i  (acc_q),
    .chunk_i(shreg_q[PAD_W-1 -: CHUNK]),
    .nxt_o  (step_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      res_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    res_d   = res_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // in_ready is implied by being in IDLE.
        if (in_valid_i) begin
          state_d = RUN;
          // Zero padding at the MSB end makes a partial top chunk harmless.
          shreg_d = PAD_W'(in_operand_i);
          acc_d   = '0;
          cnt_d   = CNT_W'(NCHUNK - 1);
        end
      end
      RUN: begin
        acc_d   = step_nxt;
        shreg_d = shreg_q << CHUNK;
        if (cnt_q == '0) begin
          state_d = DONE;
          // Separate result register so the output survives the next load of acc.
          res_d   = step_nxt;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o    = (state_q == IDLE);
  assign out_valid_o   = (state_q == DONE);
  assign busy_o        = (state_q == RUN) || (state_q == DONE);
  assign out_residue_o = res_q;

endmodule

// File: tb/tb_mod241_serial_reducer.sv
module tb_mod241_serial_reducer;

  localparam int OP_W   = 500;
  localparam int CHUNK  = 6;
  localparam int NCHUNK = 84;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_operand;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_residue;
  logic            busy;

  int checks;
  int errors;
  int acc_bad;

  // Standalone Horner-step instance for exhaustive checking.
  logic [7:0]       st_acc;
  logic [CHUNK-1:0] st_chunk;
  logic [7:0]       st_nxt;

  mod241_serial_reducer #(
    .OP_W (OP_W),
    .CHUNK(CHUNK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_operand_i (in_operand),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_residue_o(out_residue),
    .busy_o       (busy)
  );

  mod241_horner_step #(
    .CHUNK(CHUNK)
  ) u_step_tb (
    .acc_i  (st_acc),
    .chunk_i(st_chunk),
    .nxt_o  (st_nxt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The accumulator must never reach 241 while running.
  initial acc_bad = 0;
  always @(negedge clk) begin
    if (!rst && dut.acc_q >= 8'd241) acc_bad = acc_bad + 1;
  end

  // Offer one operand, measure latency to out_valid, check residue, consume it.
  task automatic run_operand(input logic [OP_W-1:0] op, input logic [7:0] exp, input string name);
    int lat;
    int waited;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    in_valid   = 1'b1;
    in_operand = op;
    out_ready  = 1'b0;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_operand = {16{32'hDEAD_BEEF}};  // must be ignored while busy
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== NCHUNK) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, NCHUNK);
    end
    checks++;
    if (out_residue !== exp) begin
      errors++;
      $display("FAIL %s residue: got %0d expected %0d", name, out_residue, exp);
    end
    $display("op %s residue %0d expected %0d latency %0d", name, out_residue, exp, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s return_idle: in_ready %0b out_valid %0b expected 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_operand = '0;
    #3;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_residue !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdy/vld/busy %b res %0d expected 100 0", {in_ready, out_valid, busy}, out_residue);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready %0b busy %0b expected 1 0", in_ready, busy);
    end
    $display("reset done");
  endtask

  task automatic test_step_exhaustive();
    int bad;
    logic [7:0] exp;
    bad = 0;
    for (int a = 0; a < 241; a++) begin
      for (int c = 0; c < (1 << CHUNK); c++) begin
        st_acc   = 8'(a);
        st_chunk = CHUNK'(c);
        #1;
        exp = 8'((a * (1 << CHUNK) + c) % 241);
        if (st_nxt !== exp) begin
          if (bad < 5) $display("FAIL step acc %0d chunk %0d: got %0d expected %0d", a, c, st_nxt, exp);
          bad++;
        end
      end
    end
    checks++;
    if (bad != 0) errors++;
    $display("step exhaustive: %0d bad pairs", bad);
  endtask

  task automatic test_basic();
    logic [OP_W-1:0] op;
    run_operand(OP_W'(240), 8'd240, "240");
    run_operand(OP_W'(241), 8'd0, "241");
    run_operand(OP_W'(256), 8'd15, "256");
    run_operand(OP_W'(0), 8'd0, "zero");
    op = '1;
    run_operand(op, 8'd225, "all_ones");
    op = '0;
    op[OP_W-1] = 1'b1;
    run_operand(op, 8'd113, "pow2_499");
  endtask

  task automatic test_backpressure();
    int lat;
    in_valid   = 1'b1;
    in_operand = OP_W'(1000);
    out_ready  = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_residue !== 8'd36 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure cyc %0d: vld %0b res %0d rdy %0b busy %0b expected 1 36 0 1",
                 i, out_valid, out_residue, in_ready, busy);
      end
      in_valid = 1'b1;  // ignored in DONE
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_residue !== 8'd36) begin
      errors++;
      $display("FAIL backpressure_release: rdy %0b vld %0b busy %0b res %0d expected 1 0 0 36",
               in_ready, out_valid, busy, out_residue);
    end
    $display("backpressure residue %0d held 10 cycles", out_residue);
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    in_valid   = 1'b1;
    in_operand = OP_W'(1);
    out_ready  = 1'b1;
    @(posedge clk); #1;
    in_operand = OP_W'(482);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (out_residue !== 8'd1 || lat !== NCHUNK) begin
      errors++;
      $display("FAIL b2b_first: res %0d lat %0d expected 1 %0d", out_residue, lat, NCHUNK);
    end
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
    end while (!(busy && !out_valid) && gap < 10);
    checks++;
    if (gap !== 2) begin
      errors++;
      $display("FAIL b2b_accept_gap: got %0d expected 2", gap);
    end
    in_valid = 1'b0;
    checks++;
    if (out_residue !== 8'd1) begin
      errors++;
      $display("FAIL b2b_hold_during_run: res %0d expected 1", out_residue);
    end
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (out_residue !== 8'd0 || lat !== NCHUNK) begin
      errors++;
      $display("FAIL b2b_second: res %0d lat %0d expected 0 %0d", out_residue, lat, NCHUNK);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("back_to_back gap %0d second residue %0d", gap, out_residue);
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    in_valid   = 1'b1;
    in_operand = OP_W'(12345);
    out_ready  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_residue !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_run: rdy/vld/busy %b res %0d expected 100 0", {in_ready, out_valid, busy}, out_residue);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_no_pulse: got %0d out_valid cycles expected 0", pulses);
    end
    $display("reset mid run abandoned");
    run_operand(OP_W'(7), 8'd7, "after_reset");
  endtask

  task automatic test_random();
    logic [511:0]    tmp;
    logic [OP_W-1:0] op;
    logic [OP_W-1:0] r;
    for (int n = 0; n < 45; n++) begin
      for (int w = 0; w < 16; w++) tmp[w*32 +: 32] = $urandom;
      if (n % 5 == 1) begin
        op = OP_W'(tmp[31:0]);                    // small operand
      end else if (n % 5 == 2) begin
        op = OP_W'(tmp[499:0]) / OP_W'(241) * OP_W'(241);  // exact multiple of 241
      end else begin
        op = tmp[OP_W-1:0];
      end
      r = op % OP_W'(241);
      run_operand(op, r[7:0], $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    st_acc = '0;
    st_chunk = '0;
    test_reset();
    test_step_exhaustive();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    checks++;
    if (acc_bad !== 0) begin
      errors++;
      $display("FAIL acc_range: %0d cycles with acc >= 241, expected 0", acc_bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
